output_bias_loader: RTL and testbench
=====================================

// Module: output_bias_loader
// PURPOSE
//  Writer side of the output-layer bias store: accepts bias bytes over a valid/ready byte stream
//  and writes them, in index order, into a NUM_NEURONS x BIAS_W register file.
//  The output layer reads the register file combinationally on bias_flat.
//  Sits between the host/config stream and the output neuron adders.
// PARAMETERS
//  NUM_NEURONS  10  number of output biases (entries 0..NUM_NEURONS-1)
//  BIAS_W       8   bias width in bits (signed two's complement, stored raw)
//  IDX_W        4   index counter width; must satisfy 2**IDX_W >= NUM_NEURONS
// PORTS
//  clk        in   1                     single clock, all logic rising-edge
//  rst        in   1                     synchronous, active-high reset
//  start      in   1                     begin a load (sampled only in IDLE)
//  in_valid   in   1                     byte on in_data is valid
//  in_data    in   BIAS_W                bias byte, entry 0 first
//  in_ready   out  1                     loader accepts byte this cycle
//  bias_flat  out  NUM_NEURONS*BIAS_W    entry i at [i*BIAS_W +: BIAS_W]
//  bias_valid out  1                     full, accepted bias set present
//  busy       out  1                     high in LOAD (and CHECK)
//  done       out  1                     one-cycle pulse when load ends
//  err        out  1                     checksum mismatch on last load (sticky until next start)
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, all entries=0, in_ready=0, bias_valid=0, busy=0, done=0, err=0.
//  - Transfer occurs on a cycle with in_valid && in_ready; no combinational path in_valid->in_ready.
//  - IDLE: in_ready=0. start=1 -> LOAD next cycle, idx<=0, bias_valid<=0, err<=0.
//  - LOAD: in_ready=1. On transfer, entry[idx]<=in_data, idx<=idx+1.
//    Transfer with idx==NUM_NEURONS-1 -> DONE (or CHECK when the checksum feature is on); idx<=0.
//    Without in_valid, state and idx hold; no timeout.
//  - DONE: one cycle: done=1, bias_valid<=1 (unless err), then IDLE.
//  - start is ignored outside IDLE. A start in the DONE cycle is ignored.
//  - bias_flat is always the register contents. During a load, already-written entries show new
//    values and unwritten entries keep old values; bias_valid=0 marks the set as incoherent.
//  - Reset mid-load clears all entries and returns to IDLE in the same cycle it is sampled.
//  - Latency: NUM_NEURONS accepted bytes + 1 cycle from the first transfer to the done pulse.
// CONFIGURATION
//  OUTPUT_BIAS_CHECKSUM_EN defined:
//    - After the last bias byte, state CHECK with in_ready=1 accepts one extra checksum byte.
//    - The sum of all NUM_NEURONS bytes plus the checksum, mod 2**BIAS_W, must equal 0.
//    - On a match: err=0 and bias_valid=1 after DONE.
//    - On a mismatch: err=1, bias_valid stays 0, and entries keep the loaded (bad) data.
//    - The running sum is a BIAS_W-bit accumulator, cleared at start.
//  Not defined: no CHECK state, no accumulator, err tied 0, DONE follows the last bias byte.
// STRUCTURE
//  - Shared package output_bias_pkg holds:
//    - the state typedef {IDLE, LOAD, CHECK, DONE};
//    - NUM_NEURONS and BIAS_W defaults;
//    - the bias_flat slice helper constant.
//  - One sub-module: bias_reg_file, containing:
//    - NUM_NEURONS x BIAS_W registers with synchronous clear;
//    - write enable, write index and write data inputs;
//    - the flat read bus.
//  - The FSM, idx counter and checksum stay in output_bias_loader.
// TESTING
//  1. Reset then start; stream bytes 0x01..0x0A with in_valid held high:
//     -> ten transfers on consecutive cycles; entry i = i+1; done pulses once; bias_valid=1.
//  2. Same stream, but in_valid drops every other cycle:
//     -> idx holds while in_valid=0; final contents identical to test 1; done exactly once.
//  3. After 5 bytes, assert rst for one cycle:
//     -> all entries 0x00, IDLE, bias_valid=0, in_ready=0 on the next cycle.
//  4. Pulse start during LOAD and during DONE; send in_valid bytes while in IDLE:
//     -> no restart, no writes, in_ready=0 in IDLE.
//  5. (OUTPUT_BIAS_CHECKSUM_EN) bytes 0x01..0x0A then checksum 0xC9:
//     -> err=0, bias_valid=1. Repeat with checksum 0xC8 -> err=1, bias_valid=0.
//  6. Load 0xFF x10, then load 0x80 x10:
//     -> bias_flat = all 0x80; bias_valid low from start until the second done pulse.

Source files
------------

// File: rtl/output_bias_pkg.sv
// Shared types and defaults for the output-layer bias loader and its register file.
package output_bias_pkg;

  localparam int NUM_NEURONS_DEF = 10;
  localparam int BIAS_W_DEF      = 8;
  localparam int IDX_W_DEF       = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Low bit of entry i on the flat bias bus.
  function automatic int slice_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/bias_reg_file.sv
// NUM_NEURONS x BIAS_W bias register file: one write port, flat combinational read bus.
module bias_reg_file
  import output_bias_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int BIAS_W      = BIAS_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [IDX_W-1:0]              widx,
  input  logic [BIAS_W-1:0]             wdata,
  output logic [NUM_NEURONS*BIAS_W-1:0] rdata_flat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [BIAS_W-1:0] mem [NUM_NEURONS];

  // NOTE: this storage is reset on purpose -- downstream adders must see zero biases
  // after reset, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else if (we && (widx <= LAST_IDX)) begin
      mem[widx] <= wdata;
    end
  end

  // NOTE: assign a default before the loop so no bit of the bus can infer a latch.
  always_comb begin
    rdata_flat = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      rdata_flat[slice_lsb(i, BIAS_W) +: BIAS_W] = mem[i];
  end

endmodule

// File: rtl/output_bias_loader.sv
// Streams bias bytes into the output-layer bias register file in index order.
// Optional trailing checksum byte: define OUTPUT_BIAS_CHECKSUM_EN.
module output_bias_loader
  import output_bias_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int BIAS_W      = BIAS_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [BIAS_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [NUM_NEURONS*BIAS_W-1:0] bias_flat,
  output logic                          bias_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             transfer;
  logic             we;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = (state == LOAD) || (state == CHECK);
  assign busy     = in_ready;
  assign done     = (state == DONE);
  assign transfer = in_valid && in_ready;
  assign we       = transfer && (state == LOAD);

  bias_reg_file #(
    .NUM_NEURONS(NUM_NEURONS),
    .BIAS_W     (BIAS_W),
    .IDX_W      (IDX_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .widx      (idx),
    .wdata     (in_data),
    .rdata_flat(bias_flat)
  );

  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      bias_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= LOAD;
          idx        <= '0;
          bias_valid <= 1'b0;
        end
        LOAD: if (transfer) begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
`ifdef OUTPUT_BIAS_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CHECK: if (transfer) state <= DONE;
        DONE: begin
          bias_valid <= !err;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_BIAS_CHECKSUM_EN
  logic [BIAS_W-1:0] sum;
  logic [BIAS_W-1:0] sum_next;
  logic              err_q;

  assign sum_next = sum + in_data;
  assign err      = err_q;

  // Bias bytes and the checksum byte all feed the sum; a valid set wraps to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (transfer) begin
      sum <= sum_next;
      if (state == CHECK) err_q <= (sum_next != '0);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_output_bias_loader.sv
// Self-checking bench for output_bias_loader: vector table, directed loads, random loads vs a model.
module tb_output_bias_loader;

  localparam int N = 10;
  localparam int W = 8;
`ifdef OUTPUT_BIAS_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic [N*W-1:0]   bias_flat;
  logic             bias_valid;
  logic             busy;
  logic             done;
  logic             err;

  output_bias_loader #(.NUM_NEURONS(N), .BIAS_W(W), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bias_flat (bias_flat),
    .bias_valid(bias_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: a load accepts N (+checksum) bytes, then one done cycle.
  logic [W-1:0] m_ent [N];
  int           m_cnt;
  int           m_sum;
  bit           m_active, m_pulse, m_bv, m_err;
  int           done_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_ent[i];
    return f;
  endfunction

  function automatic logic [W-1:0] calc_chk(input logic [W-1:0] b [N]);
    int s = 0;
    for (int i = 0; i < N; i++) s += b[i];
    return W'((1 << W) - (s % (1 << W)));
  endfunction

  // One clock: drive inputs, advance the model, compare every output.
  task automatic cycle(input bit r, input bit st, input bit v, input logic [W-1:0] d);
    rst = r; start = st; in_valid = v; in_data = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) m_ent[i] = '0;
      m_active = 0; m_pulse = 0; m_bv = 0; m_err = 0; m_cnt = 0; m_sum = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
      m_bv    = !m_err;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_cnt = 0; m_sum = 0; m_bv = 0; m_err = 0;
      end
    end else if (v) begin
      if (m_cnt < N) m_ent[m_cnt] = d;
      m_sum += d;
      m_cnt++;
      if (m_cnt == N + CHK) begin
        m_active = 0;
        m_pulse  = 1;
        if (CHK != 0) m_err = (m_sum % (1 << W)) != 0;
      end
    end
    #1;
    if (done) done_seen++;
    check("in_ready",   in_ready,   m_active);
    check("busy",       busy,       m_active);
    check("done",       done,       m_pulse);
    check("bias_valid", bias_valid, m_bv);
    check("err",        err,        m_err);
    check("bias_flat",  bias_flat,  m_flat());
  endtask

  // gap: 0 = valid every cycle, 1 = valid every other cycle, 2 = random gaps and stray starts.
  task automatic load(input logic [W-1:0] b [N], input int gap, input logic [W-1:0] ck,
                      input bit start_in_done);
    int k;
    int c;
    bit v;
    bit ph;
    done_seen = 0;
    cycle(0, 1, 0, '0);
    k = 0; c = 0; ph = 1;
    while (k < N + CHK && c < 200) begin
      case (gap)
        0:       v = 1;
        1:       v = ph;
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      ph = !ph;
      cycle(0, (gap == 2) && ($urandom_range(0, 7) == 0), v,
            v ? ((k < N) ? b[k] : ck) : W'($urandom));
      if (v) k++;
      c++;
    end
    check("done_after_last_byte", done, 1'b1);
    cycle(0, start_in_done, 0, '0);
    cycle(0, 0, 0, '0);
    check("done_pulse_count", done_seen, 1);
  endtask

  typedef struct {
    bit           r, st, v;
    logic [W-1:0] d;
    bit           e_rdy;
    logic [W-1:0] e_e0;
  } vec_t;

  vec_t         tbl [8];
  logic [W-1:0] bytes [N];
  logic [W-1:0] exp_flat_b [N];
  logic [N*W-1:0] saved;

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = '0;
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    m_active = 0; m_pulse = 0; m_bv = 0; m_err = 0; m_cnt = 0; m_sum = 0; done_seen = 0;

    tbl[0] = '{1, 0, 0, 8'h00, 0, 8'h00};  // reset
    tbl[1] = '{0, 0, 1, 8'h55, 0, 8'h00};  // byte offered in IDLE is ignored
    tbl[2] = '{0, 1, 0, 8'h00, 1, 8'h00};  // start -> LOAD
    tbl[3] = '{0, 0, 0, 8'h00, 1, 8'h00};  // no valid, holds
    tbl[4] = '{0, 1, 1, 8'h11, 1, 8'h11};  // start during LOAD ignored, entry 0 written
    tbl[5] = '{0, 0, 1, 8'h22, 1, 8'h11};  // entry 1 written
    tbl[6] = '{1, 0, 1, 8'h33, 0, 8'h00};  // reset mid-load clears everything
    tbl[7] = '{0, 0, 1, 8'h44, 0, 8'h00};  // IDLE again, no write

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].d);
      check("tbl_in_ready", in_ready, tbl[i].e_rdy);
      check("tbl_entry0",   bias_flat[W-1:0], tbl[i].e_e0);
    end

    // Bytes 0x01..0x0A, back to back.
    for (int i = 0; i < N; i++) bytes[i] = W'(i + 1);
    load(bytes, 0, calc_chk(bytes), 0);
    for (int i = 0; i < N; i++)
      check("t1_entry", bias_flat[i*W +: W], W'(i + 1));
    check("t1_bias_valid", bias_valid, 1'b1);
    check("t1_err", err, 1'b0);
    saved = bias_flat;

    // Same stream with in_valid every other cycle; start pulsed in the DONE cycle.
    load(bytes, 1, calc_chk(bytes), 1);
    check("t2_same_contents", bias_flat, saved);
    check("t4_no_restart_busy", busy, 1'b0);

    // Bytes offered in IDLE are not written.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h77);
    check("t4_idle_no_write", bias_flat, saved);
    check("t4_idle_ready", in_ready, 1'b0);

    // Reset after 5 bytes.
    cycle(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'hA0 + W'(i));
    cycle(1, 0, 1, 8'hEE);
    check("t3_entries_zero", bias_flat, {(N*W){1'b0}});
    check("t3_ready", in_ready, 1'b0);
    check("t3_bias_valid", bias_valid, 1'b0);
    cycle(0, 0, 0, '0);

`ifdef OUTPUT_BIAS_CHECKSUM_EN
    load(bytes, 0, 8'hC9, 0);
    check("t5_good_err", err, 1'b0);
    check("t5_good_bias_valid", bias_valid, 1'b1);
    load(bytes, 0, 8'hC8, 0);
    check("t5_bad_err", err, 1'b1);
    check("t5_bad_bias_valid", bias_valid, 1'b0);
    check("t5_bad_data_kept", bias_flat, saved);
`endif

    // 0xFF x10 then 0x80 x10; the model flags any early bias_valid.
    for (int i = 0; i < N; i++) bytes[i] = 8'hFF;
    load(bytes, 0, calc_chk(bytes), 0);
    for (int i = 0; i < N; i++) bytes[i] = 8'h80;
    cycle(0, 1, 0, '0);
    check("t6_bias_valid_cleared", bias_valid, 1'b0);
    for (int i = 0; i < N + CHK; i++) cycle(0, 0, 1, (i < N) ? bytes[i] : calc_chk(bytes));
    check("t6_bias_valid_before_done", bias_valid, 1'b0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    check("t6_all_0x80", bias_flat, {N{8'h80}});
    check("t6_bias_valid_after", bias_valid, 1'b1);

    // Random loads, random gaps, occasional corrupted checksum.
    for (int t = 0; t < 15; t++) begin
      logic [W-1:0] ck;
      for (int i = 0; i < N; i++) bytes[i] = W'($urandom);
      ck = calc_chk(bytes);
      if ($urandom_range(0, 3) == 0) ck = ck ^ W'($urandom_range(1, 255));
      load(bytes, 2, ck, $urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) exp_flat_b[i] = bytes[i];
      for (int i = 0; i < N; i++)
        check("rnd_entry", bias_flat[i*W +: W], exp_flat_b[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
